// File: rtl/lcb_responder.sv
// lcb_responder: RS485 half-duplex request/response slave.
// It receives a 4-byte UART request (ADDR, CMD, PARAM, CSUM) and answers
// with RSP_BYTES payload bytes read from an external RAM.
// Optional build macro: RSP_CHECKSUM_EN appends one XOR-of-payload byte.
// dbgState mirrors the FSM state for debug and checkers.
//
// RAM read handshake: rdEn is a single-cycle strobe with rdAddr stable in
// the same cycle; the RAM has no ready/stall, and iData is taken exactly
// one clk after the strobe (the second TX_LOAD cycle).
module lcb_responder #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] DEV_ADDR     = 8'h01,
  parameter int         RSP_BYTES    = 8,
  parameter int         TURN_CLKS    = 64,
  parameter int         GAP_CLKS     = 320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic       dirTX,
  output logic       dirRX,
  output logic [4:0] rdAddr,
  output logic       rdEn,
  input  logic [7:0] iData,
  output logic [7:0] oCmd,
  output logic [7:0] oParam,
  output logic       oRqValid,
  output logic       oErr,
  output logic       busy,
  output logic [2:0] dbgState
);

  typedef enum logic [2:0] {
    IDLE, RX_FRAME, CHECK, TURN, TX_LOAD, TX_SHIFT, DONE
  } state_t;

  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] TURN_END = 16'(TURN_CLKS - 1);
  localparam logic [15:0] GAP_MAX  = 16'(GAP_CLKS);
`ifdef RSP_CHECKSUM_EN
  localparam logic [4:0]  LAST_BYTE = 5'(RSP_BYTES);
`else
  localparam logic [4:0]  LAST_BYTE = 5'(RSP_BYTES - 1);
`endif

  state_t      state, stateNext;
  logic        rxMeta, rxS;
  logic [15:0] clkCnt, gapCnt;
  logic [3:0]  bitIdx;
  logic [1:0]  rxByteIdx;
  logic        rxInByte;
  logic [7:0]  shiftReg, addrB, cmdB, paramB, csumB;
  logic [7:0]  lastCmd, lastParam;
  logic [4:0]  byteIdx;
  logic        loadPh;
  logic [7:0]  txByte, loadByte;
  logic [15:0] txFrame;
  logic        isCsumByte;
  logic        sampleTick, bitDone;
  logic        errPulse, acceptReq;

  // Two-flop synchronizer for the asynchronous request line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
    end
  end

  // First sample lands mid start bit, later ones a full bit apart.
  assign sampleTick = rxInByte && (clkCnt == ((bitIdx == 4'd0) ? HALF_END : BIT_END));
  assign bitDone    = (clkCnt == BIT_END);

`ifdef RSP_CHECKSUM_EN
  logic [7:0] csumAcc;
  assign isCsumByte = (byteIdx == LAST_BYTE);
  assign loadByte   = isCsumByte ? csumAcc : iData;

  // Running XOR of the payload bytes as they are fetched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      csumAcc <= 8'h00;
    else if (state == CHECK)
      csumAcc <= 8'h00;
    else if (state == TX_LOAD && loadPh && !isCsumByte)
      csumAcc <= csumAcc ^ iData;
  end
`else
  assign isCsumByte = 1'b0;
  assign loadByte   = iData;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic and the single-cycle request/error pulses.
  always_comb begin
    stateNext = state;
    errPulse  = 1'b0;
    acceptReq = 1'b0;
    case (state)
      IDLE: if (!rxS) stateNext = RX_FRAME;
      RX_FRAME: begin
        if (rxInByte) begin
          if (sampleTick) begin
            if (bitIdx == 4'd0 && rxS && rxByteIdx == 2'd0) begin
              stateNext = IDLE;
            end else if (bitIdx == 4'd9) begin
              if (!rxS) begin
                errPulse  = 1'b1;
                stateNext = IDLE;
              end else if (rxByteIdx == 2'd3) begin
                stateNext = CHECK;
              end
            end
          end
        end else if (rxS && gapCnt >= GAP_MAX) begin
          errPulse  = 1'b1;
          stateNext = IDLE;
        end
      end
      CHECK: begin
        if (csumB != (addrB ^ cmdB ^ paramB)) begin
          errPulse  = 1'b1;
          stateNext = IDLE;
        end else if (addrB != DEV_ADDR) begin
          stateNext = IDLE;
        end else begin
          acceptReq = 1'b1;
          stateNext = TURN;
        end
      end
      TURN:     if (clkCnt == TURN_END) stateNext = TX_LOAD;
      TX_LOAD:  if (loadPh) stateNext = TX_SHIFT;
      TX_SHIFT: if (bitDone && bitIdx == 4'd9)
                  stateNext = (byteIdx == LAST_BYTE) ? DONE : TX_LOAD;
      DONE:     if (bitDone) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Datapath: bit/byte counters, receive shifter, request and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkCnt <= '0; gapCnt <= '0; bitIdx <= '0; rxByteIdx <= '0;
      rxInByte <= 1'b0; shiftReg <= '0; addrB <= '0; cmdB <= '0;
      paramB <= '0; csumB <= '0; lastCmd <= '0; lastParam <= '0;
      byteIdx <= '0; loadPh <= 1'b0; txByte <= '0;
    end else begin
      case (state)
        IDLE: begin
          clkCnt <= '0; gapCnt <= '0; bitIdx <= '0; rxByteIdx <= '0;
          loadPh <= 1'b0;
          rxInByte <= !rxS;
        end
        RX_FRAME: begin
          if (rxInByte) begin
            if (sampleTick) begin
              clkCnt <= '0;
              bitIdx <= bitIdx + 4'd1;
              if (bitIdx == 4'd0 && rxS) begin
                rxInByte <= 1'b0;
                bitIdx   <= '0;
                gapCnt   <= '0;
              end else if (bitIdx != 4'd9) begin
                shiftReg <= {rxS, shiftReg[7:1]};
              end else begin
                case (rxByteIdx)
                  2'd0: addrB  <= shiftReg;
                  2'd1: cmdB   <= shiftReg;
                  2'd2: paramB <= shiftReg;
                  2'd3: csumB  <= shiftReg;
                endcase
                rxByteIdx <= rxByteIdx + 2'd1;
                rxInByte  <= 1'b0;
                bitIdx    <= '0;
                gapCnt    <= '0;
              end
            end else begin
              clkCnt <= clkCnt + 16'd1;
            end
          end else if (!rxS) begin
            rxInByte <= 1'b1;
            clkCnt   <= '0;
            bitIdx   <= '0;
          end else begin
            gapCnt <= gapCnt + 16'd1;
          end
        end
        CHECK: begin
          clkCnt  <= '0;
          byteIdx <= '0;
          loadPh  <= 1'b0;
          if (acceptReq) begin
            lastCmd   <= cmdB;
            lastParam <= paramB;
          end
        end
        TURN: clkCnt <= clkCnt + 16'd1;
        TX_LOAD: begin
          clkCnt <= '0;
          bitIdx <= '0;
          loadPh <= !loadPh;
          if (loadPh) txByte <= loadByte;
        end
        TX_SHIFT: begin
          if (bitDone) begin
            clkCnt <= '0;
            bitIdx <= bitIdx + 4'd1;
            if (bitIdx == 4'd9 && byteIdx != LAST_BYTE) byteIdx <= byteIdx + 5'd1;
          end else begin
            clkCnt <= clkCnt + 16'd1;
          end
        end
        DONE: clkCnt <= clkCnt + 16'd1;
        default: clkCnt <= '0;
      endcase
    end
  end

  // Serial output and bus-direction decode straight from the state, so
  // an asynchronous reset releases the bus without waiting for a clock.
  always_comb begin
    txFrame  = {6'h3F, 1'b1, txByte, 1'b0};
    tx       = (state == TX_SHIFT) ? txFrame[bitIdx] : 1'b1;
    dirTX    = (state == TURN) || (state == TX_LOAD) ||
               (state == TX_SHIFT) || (state == DONE);
    dirRX    = !dirTX;
    rdEn     = (state == TX_LOAD) && !loadPh && !isCsumByte;
    rdAddr   = byteIdx;
    oRqValid = acceptReq;
    oErr     = errPulse;
    oCmd     = acceptReq ? cmdB : lastCmd;
    oParam   = acceptReq ? paramB : lastParam;
    busy     = (state != IDLE);
    dbgState = state;
  end

endmodule

// File: tb/tb_lcb_responder.sv
// Self-checking bench for lcb_responder: UART request driver, RAM model,
// tx byte monitor against an expected-byte queue, per-scenario test tasks.
module tb_lcb_responder;

  localparam int CPB       = 16;
  localparam int RSP_BYTES = 8;
  localparam int TURN_CLKS = 64;
  localparam int GAP_CLKS  = 320;
  localparam int CLK_NS    = 10;
`ifdef RSP_CHECKSUM_EN
  localparam int N_RSP = RSP_BYTES + 1;
`else
  localparam int N_RSP = RSP_BYTES;
`endif
  localparam int GAP_MAX_NS = (CPB / 2 + 2) * CLK_NS + CLK_NS / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       tx, dirTX, dirRX, rdEn, oRqValid, oErr, busy;
  logic [4:0] rdAddr;
  logic [7:0] iData = 8'h00;
  logic [7:0] oCmd, oParam;
  logic [2:0] dbgState;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] ram [0:31];
  logic [7:0] exp_q[$];

  lcb_responder #(
    .CLKS_PER_BIT(CPB), .DEV_ADDR(8'h01), .RSP_BYTES(RSP_BYTES),
    .TURN_CLKS(TURN_CLKS), .GAP_CLKS(GAP_CLKS)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .dirTX(dirTX), .dirRX(dirRX),
    .rdAddr(rdAddr), .rdEn(rdEn), .iData(iData), .oCmd(oCmd), .oParam(oParam),
    .oRqValid(oRqValid), .oErr(oErr), .busy(busy), .dbgState(dbgState)
  );

  // Clock and watchdog.
  always #(CLK_NS / 2) clk = ~clk;
  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
    $fatal(1, "watchdog");
  end

  // Payload RAM model: data valid one clk after the read strobe.
  always @(posedge clk) if (rdEn) iData <= ram[rdAddr];

  // Pulse / bus activity tracker, sampled on the falling clock edge.
  int   rq_cnt = 0, err_cnt = 0;
  logic [7:0] rq_cmd, rq_param;
  logic rq_dirtx;
  time  rq_time, rise_time, first_fall_time;
  bit   dirtx_seen = 0, tx_low_seen = 0, fall_armed = 0;
  logic dirtx_d = 1'b0;
  always @(negedge clk) begin
    if (oRqValid) begin
      rq_cnt++; rq_cmd = oCmd; rq_param = oParam; rq_dirtx = dirTX; rq_time = $time;
    end
    if (oErr) err_cnt++;
    if (dirTX) dirtx_seen = 1;
    if (!tx) tx_low_seen = 1;
    if (dirTX && !dirtx_d) begin rise_time = $time; fall_armed = 1; end
    if (fall_armed && !tx) begin first_fall_time = $time; fall_armed = 0; end
    dirtx_d = dirTX;
  end

  // tx monitor: decodes response bytes and pops the scoreboard.
  int         resp_bytes = 0;
  logic [7:0] mon_byte, mon_last_byte, exp_b;
  logic       mon_stop;
  bit         mon_abort;
  time        mon_t0, last_stop_time;
  always begin
    @(negedge tx);
    if (dirTX && !rst) begin
      mon_t0 = $time; mon_abort = 0;
      if (resp_bytes > 0) begin
        n_compared++;
        if (mon_t0 - last_stop_time > GAP_MAX_NS) begin
          n_mismatched++;
          $display("FAIL byte_gap: got %0t from stop sample, need <= %0d ns", mon_t0 - last_stop_time, GAP_MAX_NS);
        end
      end
      repeat (CPB / 2) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(negedge clk);
        mon_byte[b] = tx;
        if (rst || !dirTX) mon_abort = 1;
      end
      repeat (CPB) @(negedge clk);
      mon_stop = tx;
      if (rst || !dirTX) mon_abort = 1;
      last_stop_time = $time;
      if (!mon_abort) begin
        resp_bytes++;
        mon_last_byte = mon_byte;
        n_compared++;
        if (exp_q.size() == 0) begin
          n_mismatched++;
          $display("FAIL unexpected_byte: got %h with empty expected queue", mon_byte);
        end else begin
          exp_b = exp_q.pop_front();
          if ({mon_stop, mon_byte} !== {1'b1, exp_b}) begin
            n_mismatched++;
            $display("FAIL tx_byte: got %h stop %b, need %h stop 1", mon_byte, mon_stop, exp_b);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (3 * CPB / 4) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_req(input logic [7:0] a, input logic [7:0] c,
                          input logic [7:0] p, input logic [7:0] s);
    send_byte(a, 1); send_byte(c, 1); send_byte(p, 1); send_byte(s, 1);
  endtask

  task automatic push_expected();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < RSP_BYTES; i++) begin
      exp_q.push_back(ram[i]);
      x = x ^ ram[i];
    end
`ifdef RSP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic fill_ram_random();
    for (int i = 0; i < 32; i++) ram[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(negedge clk);
    n_compared++; if (tx !== 1'b1)       begin n_mismatched++; $display("FAIL reset_tx: got %b need 1", tx); end
    n_compared++; if (dirTX !== 1'b0)    begin n_mismatched++; $display("FAIL reset_dirTX: got %b need 0", dirTX); end
    n_compared++; if (dirRX !== 1'b1)    begin n_mismatched++; $display("FAIL reset_dirRX: got %b need 1", dirRX); end
    n_compared++; if (rdEn !== 1'b0)     begin n_mismatched++; $display("FAIL reset_rdEn: got %b need 0", rdEn); end
    n_compared++; if (rdAddr !== 5'd0)   begin n_mismatched++; $display("FAIL reset_rdAddr: got %h need 0", rdAddr); end
    n_compared++; if (oCmd !== 8'h00)    begin n_mismatched++; $display("FAIL reset_oCmd: got %h need 00", oCmd); end
    n_compared++; if (oParam !== 8'h00)  begin n_mismatched++; $display("FAIL reset_oParam: got %h need 00", oParam); end
    n_compared++; if (oRqValid !== 1'b0) begin n_mismatched++; $display("FAIL reset_oRqValid: got %b need 0", oRqValid); end
    n_compared++; if (oErr !== 1'b0)     begin n_mismatched++; $display("FAIL reset_oErr: got %b need 0", oErr); end
    n_compared++; if (busy !== 1'b0)     begin n_mismatched++; $display("FAIL reset_busy: got %b need 0", busy); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_valid_request();
    int rq0, err0; bit ok;
    fill_ram_random(); push_expected();
    resp_bytes = 0; rq0 = rq_cnt; err0 = err_cnt;
    send_req(8'h01, 8'h5A, 8'h03, 8'h58);
    wait_idle(4000, ok);
    n_compared++; if (!ok) begin n_mismatched++; $display("FAIL valid_done: busy still high, need low within 4000 clk"); end
    n_compared++; if (rq_cnt - rq0 !== 1) begin n_mismatched++; $display("FAIL valid_rq_pulses: got %0d need 1", rq_cnt - rq0); end
    n_compared++; if (err_cnt - err0 !== 0) begin n_mismatched++; $display("FAIL valid_err_pulses: got %0d need 0", err_cnt - err0); end
    n_compared++; if (rq_cmd !== 8'h5A) begin n_mismatched++; $display("FAIL valid_oCmd: got %h need 5a", rq_cmd); end
    n_compared++; if (rq_param !== 8'h03) begin n_mismatched++; $display("FAIL valid_oParam: got %h need 03", rq_param); end
    n_compared++; if (rq_dirtx !== 1'b0) begin n_mismatched++; $display("FAIL valid_dirTX_in_check: got %b need 0", rq_dirtx); end
    n_compared++; if (rise_time - rq_time != CLK_NS) begin n_mismatched++; $display("FAIL valid_dirTX_rise: got %0t after pulse, need %0d ns", rise_time - rq_time, CLK_NS); end
    n_compared++;
    if (first_fall_time - rise_time < TURN_CLKS * CLK_NS || first_fall_time - rise_time > (TURN_CLKS + 2) * CLK_NS) begin
      n_mismatched++; $display("FAIL valid_turnaround: got %0t, need %0d..%0d ns", first_fall_time - rise_time, TURN_CLKS * CLK_NS, (TURN_CLKS + 2) * CLK_NS);
    end
    n_compared++; if (resp_bytes !== N_RSP) begin n_mismatched++; $display("FAIL valid_byte_count: got %0d need %0d", resp_bytes, N_RSP); end
    n_compared++; if (exp_q.size() !== 0) begin n_mismatched++; $display("FAIL valid_queue_left: got %0d need 0", exp_q.size()); end
    n_compared++; if (dirTX !== 1'b0 || tx !== 1'b1) begin n_mismatched++; $display("FAIL valid_bus_release: got dirTX %b tx %b need 0 1", dirTX, tx); end
    exp_q.delete();
  endtask

  task automatic test_bad_csum();
    int rq0, err0;
    rq0 = rq_cnt; err0 = err_cnt; dirtx_seen = 0; tx_low_seen = 0;
    send_req(8'h01, 8'h5A, 8'h03, 8'h59);
    repeat (200) @(negedge clk);
    n_compared++; if (err_cnt - err0 !== 1) begin n_mismatched++; $display("FAIL csum_err_pulses: got %0d need 1", err_cnt - err0); end
    n_compared++; if (rq_cnt - rq0 !== 0) begin n_mismatched++; $display("FAIL csum_rq_pulses: got %0d need 0", rq_cnt - rq0); end
    n_compared++; if (dirtx_seen || tx_low_seen) begin n_mismatched++; $display("FAIL csum_bus: got dirTX_seen %0d tx_low_seen %0d need 0 0", dirtx_seen, tx_low_seen); end
  endtask

  task automatic test_wrong_addr();
    int rq0, err0;
    rq0 = rq_cnt; err0 = err_cnt; dirtx_seen = 0;
    send_req(8'h02, 8'h5A, 8'h03, 8'h5B);
    repeat (200) @(negedge clk);
    n_compared++; if (err_cnt - err0 !== 0) begin n_mismatched++; $display("FAIL addr_err_pulses: got %0d need 0", err_cnt - err0); end
    n_compared++; if (rq_cnt - rq0 !== 0) begin n_mismatched++; $display("FAIL addr_rq_pulses: got %0d need 0", rq_cnt - rq0); end
    n_compared++; if (dirtx_seen) begin n_mismatched++; $display("FAIL addr_dirTX: got high, need stays 0"); end
  endtask

  task automatic test_stop_bit_err();
    int err0;
    err0 = err_cnt;
    send_byte(8'h01, 0);
    repeat (200) @(negedge clk);
    n_compared++; if (err_cnt - err0 !== 1) begin n_mismatched++; $display("FAIL stop_err_pulses: got %0d need 1", err_cnt - err0); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL stop_err_busy: got %b need 0", busy); end
  endtask

  task automatic test_timeout();
    int rq0, err0; bit ok;
    err0 = err_cnt;
    send_byte(8'h01, 1); send_byte(8'h5A, 1);
    repeat (400) @(negedge clk);
    n_compared++; if (err_cnt - err0 !== 1) begin n_mismatched++; $display("FAIL timeout_err_pulses: got %0d need 1", err_cnt - err0); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL timeout_busy: got %b need 0", busy); end
    fill_ram_random(); push_expected();
    resp_bytes = 0; rq0 = rq_cnt;
    send_req(8'h01, 8'h33, 8'h44, 8'h76);
    wait_idle(4000, ok);
    n_compared++; if (!ok || rq_cnt - rq0 !== 1) begin n_mismatched++; $display("FAIL timeout_recover: got done %0d pulses %0d need 1 1", ok, rq_cnt - rq0); end
    n_compared++; if (rq_cmd !== 8'h33 || rq_param !== 8'h44) begin n_mismatched++; $display("FAIL timeout_recover_fields: got %h %h need 33 44", rq_cmd, rq_param); end
    n_compared++; if (resp_bytes !== N_RSP || exp_q.size() !== 0) begin n_mismatched++; $display("FAIL timeout_recover_bytes: got %0d left %0d need %0d 0", resp_bytes, exp_q.size(), N_RSP); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] c, p; int rq0; bit ok;
    for (int k = 0; k < 2; k++) begin
      c = 8'($urandom_range(0, 255)); p = 8'($urandom_range(0, 255));
      fill_ram_random(); push_expected();
      resp_bytes = 0; rq0 = rq_cnt;
      send_req(8'h01, c, p, 8'h01 ^ c ^ p);
      wait_idle(4000, ok);
      n_compared++; if (!ok || rq_cnt - rq0 !== 1) begin n_mismatched++; $display("FAIL b2b_accept[%0d]: got done %0d pulses %0d need 1 1", k, ok, rq_cnt - rq0); end
      n_compared++; if (rq_cmd !== c || rq_param !== p) begin n_mismatched++; $display("FAIL b2b_fields[%0d]: got %h %h need %h %h", k, rq_cmd, rq_param, c, p); end
      n_compared++; if (resp_bytes !== N_RSP || exp_q.size() !== 0) begin n_mismatched++; $display("FAIL b2b_bytes[%0d]: got %0d left %0d need %0d 0", k, resp_bytes, exp_q.size(), N_RSP); end
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_tx();
    int rq0; bit found;
    fill_ram_random(); push_expected();
    resp_bytes = 0; found = 0;
    send_req(8'h01, 8'h5A, 8'h03, 8'h58);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (dbgState == 3'd5 && rdAddr == 5'd2) begin found = 1; break; end
    end
    n_compared++; if (!found) begin n_mismatched++; $display("FAIL midtx_reach_byte3: not reached within 4000 clk"); end
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_compared++; if (tx !== 1'b1) begin n_mismatched++; $display("FAIL midtx_tx: got %b need 1", tx); end
    n_compared++; if (dirTX !== 1'b0) begin n_mismatched++; $display("FAIL midtx_dirTX: got %b need 0", dirTX); end
    repeat (3) @(negedge clk);
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL midtx_busy: got %b need 0", busy); end
    rst = 1'b0;
    exp_q.delete();
    dirtx_seen = 0; tx_low_seen = 0; rq0 = rq_cnt;
    repeat (400) @(negedge clk);
    n_compared++; if (dirtx_seen || tx_low_seen || rq_cnt != rq0) begin n_mismatched++; $display("FAIL midtx_no_resume: got dirTX %0d tx_low %0d pulses %0d need 0 0 0", dirtx_seen, tx_low_seen, rq_cnt - rq0); end
  endtask

`ifdef RSP_CHECKSUM_EN
  task automatic test_csum_byte();
    bit ok;
    for (int i = 0; i < 32; i++) ram[i] = 8'(i + 1);
    push_expected();
    resp_bytes = 0;
    send_req(8'h01, 8'h5A, 8'h03, 8'h58);
    wait_idle(4000, ok);
    n_compared++; if (!ok || resp_bytes !== RSP_BYTES + 1) begin n_mismatched++; $display("FAIL csum_byte_count: got done %0d bytes %0d need 1 %0d", ok, resp_bytes, RSP_BYTES + 1); end
    n_compared++; if (mon_last_byte !== 8'h08) begin n_mismatched++; $display("FAIL csum_byte_value: got %h need 08", mon_last_byte); end
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_valid_request();
    test_bad_csum();
    test_wrong_addr();
    test_stop_bit_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid_tx();
`ifdef RSP_CHECKSUM_EN
    test_csum_byte();
`endif
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
